// File: rtl/uart_value_receiver_pkg.sv
// Shared definitions for the UART value receiver: ASCII codes, state encodings,
// datapath widths and the clock-divider formula (also used by the transmitter).
package uart_value_receiver_pkg;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;

  localparam int unsigned VALUE_W    = 15;
  localparam int unsigned ACC_CALC_W = 18;
  localparam int unsigned NDIG_W     = 3;
  localparam int unsigned MAX_DIGITS = 5;
  localparam int unsigned MAG_LIMIT  = 16384;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_SIGN = 2'd1,
    P_DIG  = 2'd2,
    P_ERR  = 2'd3
  } parse_state_t;

  // Clocks per oversampling tick.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    return clk_freq / (baud * ovs);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASC_CR) || (b == ASC_LF);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: RxD synchronizer, oversampling tick divider and byte FSM.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   RxD         - asynchronous serial input, idle high
//   rx_data     - last received byte (valid while byte_valid is high)
//   byte_valid  - 1-cycle pulse per byte with a good stop bit
//   frame_err   - 1-cycle pulse when the stop bit is sampled low
//   busy        - high from start-bit detect until the stop-bit sample
module uart_rx_byte
  import uart_value_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = 16,
  parameter int unsigned DIV      = calc_div(CLK_FREQ, BAUD, OVS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV_W        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W       = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned START_SAMPLE = OVS / 2 - 1;
  localparam int unsigned BIT_SAMPLE   = OVS - 1;

  rx_state_t         state, state_next;
  logic              rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic              tick_c, fall_c, sample_c;
  logic              byte_valid_c, frame_err_c, busy_c;

  // Synchronizer plus one extra stage for falling-edge detection; idle level is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_c = rx_prev & ~rx_sync;

  // Free-running tick divider.
  assign tick_c = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)       div_cnt <= '0;
    else if (tick_c) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  // Start bit is sampled mid-bit; every later sample is one full bit further on.
  assign sample_c = tick_c &&
                    (tick_cnt == ((state == RX_START) ? TICK_W'(START_SAMPLE)
                                                      : TICK_W'(BIT_SAMPLE)));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall_c) state_next = RX_START;
      RX_START: if (sample_c) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample_c && (bit_cnt == 3'd7)) state_next = RX_STOP;
      RX_STOP:  if (sample_c) state_next = rx_sync ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_sync) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    busy_c       = (state_next == RX_START) || (state_next == RX_DATA) ||
                   (state_next == RX_STOP);
    if ((state == RX_STOP) && sample_c) begin
      byte_valid_c = rx_sync;
      frame_err_c  = ~rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      byte_valid <= byte_valid_c;
      frame_err  <= frame_err_c;
      busy       <= busy_c;
    end
  end

  // Tick/bit counters and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
    end else if (state == RX_IDLE) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tick_c) begin
      tick_cnt <= sample_c ? '0 : tick_cnt + TICK_W'(1);
      if ((state == RX_DATA) && sample_c) begin
        rx_data <= {rx_sync, rx_data[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_value_receiver.sv
// UART value receiver: decodes ASCII decimal lines ("[-]d{1,5}" + CR/LF) from
// the serial line into a 15-bit two's-complement value.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   RxD          - asynchronous serial input, idle high
//   value_out    - last good decoded value
//   value_valid  - 1-cycle pulse when value_out updates
//   frame_err    - 1-cycle pulse on a low stop bit
//   parse_err    - 1-cycle pulse per rejected line
//   busy         - byte receiver is inside a frame
module uart_value_receiver
  import uart_value_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = 16,
  parameter int unsigned DIV      = calc_div(CLK_FREQ, BAUD, OVS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               RxD,
  output logic [VALUE_W-1:0] value_out,
  output logic               value_valid,
  output logic               frame_err,
  output logic               parse_err,
  output logic               busy
);

  logic [7:0]            rx_data;
  logic                  byte_valid;
  parse_state_t          pstate, pstate_next;
  logic [VALUE_W-1:0]    acc;
  logic                  neg;
  logic [NDIG_W-1:0]     ndig;
  logic                  digit_c, term_c, minus_c, overflow_c;
  logic [3:0]            dval_c;
  logic [ACC_CALC_W-1:0] acc_mul_c;
  logic                  value_valid_c, parse_err_c;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS),
    .DIV      (DIV)
  ) u_rx_byte (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Byte classification and next accumulator value (acc*10 + d as shifts).
  assign digit_c   = is_digit(rx_data);
  assign term_c    = is_term(rx_data);
  assign minus_c   = (rx_data == ASC_MINUS);
  assign dval_c    = 4'(rx_data - ASC_0);
  assign acc_mul_c = (ACC_CALC_W'(acc) << 3) + (ACC_CALC_W'(acc) << 1) + ACC_CALC_W'(dval_c);

  // 16384 is only representable as a negative value.
  assign overflow_c = (ndig == NDIG_W'(MAX_DIGITS)) ||
                      (acc_mul_c > ACC_CALC_W'(MAG_LIMIT)) ||
                      ((acc_mul_c == ACC_CALC_W'(MAG_LIMIT)) && !neg);

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) pstate <= P_IDLE;
    else       pstate <= pstate_next;
  end

  // Parser next-state logic; only moves on a received byte.
  always_comb begin
    pstate_next = pstate;
    if (byte_valid) begin
      case (pstate)
        P_IDLE: begin
          if (minus_c)      pstate_next = P_SIGN;
          else if (digit_c) pstate_next = P_DIG;
          else if (!term_c) pstate_next = P_ERR;
        end
        P_SIGN: begin
          if (digit_c)     pstate_next = P_DIG;
          else if (term_c) pstate_next = P_IDLE;
          else             pstate_next = P_ERR;
        end
        P_DIG: begin
          if (digit_c)     pstate_next = overflow_c ? P_ERR : P_DIG;
          else if (term_c) pstate_next = P_IDLE;
          else             pstate_next = P_ERR;
        end
        P_ERR:   if (term_c) pstate_next = P_IDLE;
        default: pstate_next = P_IDLE;
      endcase
    end
  end

  // Parser output decode.
  always_comb begin
    value_valid_c = 1'b0;
    parse_err_c   = 1'b0;
    if (byte_valid && term_c) begin
      value_valid_c = (pstate == P_DIG);
      parse_err_c   = (pstate == P_SIGN) || (pstate == P_ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_out   <= '0;
      value_valid <= 1'b0;
      parse_err   <= 1'b0;
    end else begin
      value_valid <= value_valid_c;
      parse_err   <= parse_err_c;
      if (value_valid_c) value_out <= neg ? VALUE_W'(-acc) : acc;
    end
  end

  // Accumulator, sign flag and digit count.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      neg  <= 1'b0;
      ndig <= '0;
    end else if (byte_valid) begin
      case (pstate)
        P_IDLE: begin
          if (minus_c) begin
            neg  <= 1'b1;
            acc  <= '0;
            ndig <= '0;
          end else if (digit_c) begin
            neg  <= 1'b0;
            acc  <= VALUE_W'(dval_c);
            ndig <= NDIG_W'(1);
          end
        end
        P_SIGN: begin
          if (digit_c) begin
            acc  <= VALUE_W'(dval_c);
            ndig <= NDIG_W'(1);
          end
        end
        P_DIG: begin
          if (digit_c && !overflow_c) begin
            acc  <= VALUE_W'(acc_mul_c);
            ndig <= ndig + NDIG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_value_receiver.sv
// Directed bench for uart_value_receiver at 1 Mbaud / 100 MHz (DIV = 6).
module tb_uart_value_receiver;

  localparam int BIT_T = 960;  // 96 clocks of 10 time units per bit
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic        clk = 1'b0;
  logic        reset;
  logic        RxD;
  logic [14:0] value_out;
  logic        value_valid, frame_err, parse_err, busy;

  int n_total = 0;
  int n_pass  = 0;
  int vv_cnt = 0, pe_cnt = 0, fe_cnt = 0, bv_cnt = 0;
  int vv0, pe0, fe0, bv0;

  uart_value_receiver #(
    .CLK_FREQ (100_000_000),
    .BAUD     (1_000_000),
    .OVS      (16)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .RxD         (RxD),
    .value_out   (value_out),
    .value_valid (value_valid),
    .frame_err   (frame_err),
    .parse_err   (parse_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pulse counters and value_valid/parse_err exclusivity.
  always @(negedge clk) begin
    if (value_valid) vv_cnt++;
    if (parse_err)   pe_cnt++;
    if (frame_err)   fe_cnt++;
    if (u_dut.byte_valid) bv_cnt++;
    if (value_valid || parse_err) chk("exclusive", 32'(value_valid & parse_err), 32'd0);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    RxD = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      #(BIT_T);
    end
    RxD = stop_ok;
    #(BIT_T);
    if (!stop_ok) begin
      #(BIT_T);
      RxD = 1'b1;
      #(BIT_T);
    end
    RxD = 1'b1;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    send_byte(CR, 1'b1);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    vv0 = vv_cnt; pe0 = pe_cnt; fe0 = fe_cnt; bv0 = bv_cnt;
  endtask

  initial begin
    RxD   = 1'b1;
    reset = 1'b1;
    wait_clks(5);
    chk("rst_value", 32'(value_out), 32'd0);
    chk("rst_valid", 32'(value_valid), 32'd0);
    chk("rst_perr", 32'(parse_err), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_clks(10);

    // Plain positive value.
    snap();
    send_line("102");
    wait_clks(20);
    chk("v102_value", 32'(value_out), 32'd102);
    chk("v102_nvalid", 32'(vv_cnt - vv0), 32'd1);
    chk("v102_nperr", 32'(pe_cnt - pe0), 32'd0);
    chk("v102_nferr", 32'(fe_cnt - fe0), 32'd0);

    // Negative value with CRLF: LF after CR is ignored.
    snap();
    send_line("-70");
    send_byte(LF, 1'b1);
    wait_clks(20);
    chk("m70_value", 32'(value_out), 32'h7FBA);
    chk("m70_nvalid", 32'(vv_cnt - vv0), 32'd1);
    chk("m70_nperr", 32'(pe_cnt - pe0), 32'd0);

    // Range boundaries.
    send_line("16383");
    wait_clks(20);
    chk("max_pos", 32'(value_out), 32'h3FFF);
    send_line("-16384");
    wait_clks(20);
    chk("max_neg", 32'(value_out), 32'h4000);
    snap();
    send_line("16384");
    wait_clks(20);
    chk("ovf_nperr", 32'(pe_cnt - pe0), 32'd1);
    chk("ovf_nvalid", 32'(vv_cnt - vv0), 32'd0);
    chk("ovf_hold", 32'(value_out), 32'h4000);

    // Bad lines: bad char, too many digits, sign only.
    snap();
    send_line("1a2");
    send_line("123456");
    send_line("-");
    wait_clks(20);
    chk("bad_nperr", 32'(pe_cnt - pe0), 32'd3);
    chk("bad_nvalid", 32'(vv_cnt - vv0), 32'd0);
    send_line("5");
    wait_clks(20);
    chk("after_bad", 32'(value_out), 32'd5);
    send_line("-0");
    wait_clks(20);
    chk("minus_zero", 32'(value_out), 32'd0);

    // Stop bit held low: frame error, byte dropped, receiver recovers.
    snap();
    send_byte("7", 1'b0);
    wait_clks(20);
    chk("ferr_n", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_nbyte", 32'(bv_cnt - bv0), 32'd0);
    send_byte(CR, 1'b1);
    send_line("9");
    wait_clks(20);
    chk("ferr_recover", 32'(value_out), 32'd9);
    chk("ferr_nvalid", 32'(vv_cnt - vv0), 32'd1);
    chk("ferr_nperr", 32'(pe_cnt - pe0), 32'd0);

    // Start-bit glitch of 3 clocks.
    snap();
    RxD = 1'b0;
    wait_clks(3);
    RxD = 1'b1;
    wait_clks(2);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    wait_clks(100);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    chk("glitch_nbyte", 32'(bv_cnt - bv0), 32'd0);

    // Reset in the middle of "12": no pulses, outputs cleared, parser restarted.
    snap();
    send_byte("1", 1'b1);
    RxD = 1'b0;
    #(BIT_T * 3);
    reset = 1'b1;
    wait_clks(3);
    RxD = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(20);
    chk("rst_mid_value", 32'(value_out), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_pulses", 32'((vv_cnt - vv0) + (pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);
    send_line("3");
    wait_clks(20);
    chk("rst_mid_fresh", 32'(value_out), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
